lsu_ctrl: RTL and testbench

//  Load/store sequencer between the decoder's memory-access controls and a single-port data bus.
//  It captures a load/store in IDLE, checks alignment, and drives a req/gnt + rvalid bus transaction.

---
 rtl/lsu_bus_if.sv | 28 ++
 rtl/lsu_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if.sv
// Single-port data bus between the LSU (master) and memory (slave): req/gnt address
// phase followed by an rvalid response phase carrying read data or a write ack.
interface lsu_bus_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      bus_req;
  logic                      bus_we;
  logic [ADDR_WIDTH-1:0]     bus_addr;
  logic [DATA_WIDTH/8-1:0]   bus_be;
  logic [DATA_WIDTH-1:0]     bus_wdata;
  logic                      bus_gnt;
  logic                      bus_rvalid;
  logic [DATA_WIDTH-1:0]     bus_rdata;
  logic                      bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: captures one access from the decoder in idle, checks alignment,
// runs a single req/gnt + rvalid bus transaction and retires it with a one-cycle result
// (load write-back, misalignment flag or bus-error flag). Holds the pipeline via lsu_stall.
module lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mem_access_type,
  input  logic [1:0]            mem_access_size,
  input  logic                  mem_sign_ext,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [4:0]            reg_waddr,
  output logic                  lsu_stall,
  output logic                  lsu_wb_en,
  output logic [4:0]            lsu_wb_addr,
  output logic [DATA_WIDTH-1:0] lsu_wb_data,
  output logic                  lsu_misalign,
  output logic                  lsu_bus_err,
  lsu_bus_if.master             bus
);

  localparam logic [1:0] TypeRead  = 2'b01;
  localparam logic [1:0] TypeWrite = 2'b10;
  localparam logic [1:0] SizeNone  = 2'b00;
  localparam logic [1:0] SizeByte  = 2'b01;
  localparam logic [1:0] SizeHalf  = 2'b10;
  localparam logic [1:0] SizeWord  = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e state_q, state_d;

  // Latched copy of the access; decoder inputs are ignored once we leave idle.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            waddr_q;
  logic                  we_q;
  logic                  misalign_q;
  // Response capture.
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  access_valid;
  logic                  access_misalign;
  logic                  capture;
  logic                  resp_take;
  logic [3:0]            be_steer;
  logic [DATA_WIDTH-1:0] wdata_steer;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  // Decode of the incoming access: type 11 and size NONE are treated as no access.
  always_comb begin
    access_valid    = ((mem_access_type == TypeRead) || (mem_access_type == TypeWrite)) &&
                      (mem_access_size != SizeNone);
    access_misalign = ((mem_access_size == SizeHalf) && mem_addr[0]) ||
                      ((mem_access_size == SizeWord) && (mem_addr[1:0] != 2'b00));
    capture         = (state_q == StIdle) && access_valid;
    resp_take       = (state_q == StWait) && bus.bus_rvalid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rvalid only counts once the request has been granted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (access_valid) begin
          state_d = access_misalign ? StDone : StReq;
        end
      end
      StReq: begin
        if (bus.bus_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.bus_rvalid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Access and response capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= SizeNone;
      sign_q     <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (capture) begin
        addr_q     <= mem_addr;
        size_q     <= mem_access_size;
        sign_q     <= mem_sign_ext;
        wdata_q    <= mem_wdata;
        waddr_q    <= reg_waddr;
        we_q       <= (mem_access_type == TypeWrite);
        misalign_q <= access_misalign;
        err_q      <= 1'b0;
      end
      if (resp_take) begin
        rdata_q <= ld_ext;
        err_q   <= bus.bus_err;
      end
    end
  end

  // Store lane steering: byte enables follow the low address bits, data is replicated
  // so the selected lanes carry the value regardless of offset.
  always_comb begin
    be_steer    = 4'b0000;
    wdata_steer = wdata_q;
    case (size_q)
      SizeByte: begin
        be_steer    = 4'b0001 << addr_q[1:0];
        wdata_steer = {4{wdata_q[7:0]}};
      end
      SizeHalf: begin
        be_steer    = 4'b0011 << addr_q[1:0];
        wdata_steer = {2{wdata_q[15:0]}};
      end
      SizeWord: begin
        be_steer    = 4'b1111;
        wdata_steer = wdata_q;
      end
      default: begin
        be_steer    = 4'b0000;
        wdata_steer = wdata_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension of the raw bus word.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_byte = bus.bus_rdata[7:0];
      2'd1: ld_byte = bus.bus_rdata[15:8];
      2'd2: ld_byte = bus.bus_rdata[23:16];
      2'd3: ld_byte = bus.bus_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (size_q)
      SizeByte: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
      SizeHalf: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default:  ld_ext = bus.bus_rdata;
    endcase
  end

  // Outputs: bus signals are only live in REQ, result pulses only in DONE.
  always_comb begin
    lsu_stall     = 1'b0;
    lsu_wb_en     = 1'b0;
    lsu_misalign  = 1'b0;
    lsu_bus_err   = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = '0;
    bus.bus_wdata = '0;
    unique case (state_q)
      StIdle: begin
        lsu_stall = access_valid;
      end
      StReq: begin
        lsu_stall     = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.bus_be    = be_steer;
        bus.bus_wdata = wdata_steer;
      end
      StWait: begin
        lsu_stall = 1'b1;
      end
      StDone: begin
        lsu_wb_en    = !we_q && !misalign_q && !err_q && (waddr_q != 5'd0);
        lsu_misalign = misalign_q;
        lsu_bus_err  = err_q;
      end
      default: begin
        lsu_stall = 1'b0;
      end
    endcase
  end

  assign lsu_wb_addr = waddr_q;
  assign lsu_wb_data = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: the bench plays decoder and memory, checks bus phases,
// stall length and the retirement pulse against hand-computed values.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_access_type;
  logic [1:0]  mem_access_size;
  logic        mem_sign_ext;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  reg_waddr;
  logic        lsu_stall;
  logic        lsu_wb_en;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data;
  logic        lsu_misalign;
  logic        lsu_bus_err;

  int n_total;
  int n_bad;

  lsu_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_access_type (mem_access_type),
    .mem_access_size (mem_access_size),
    .mem_sign_ext    (mem_sign_ext),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .reg_waddr       (reg_waddr),
    .lsu_stall       (lsu_stall),
    .lsu_wb_en       (lsu_wb_en),
    .lsu_wb_addr     (lsu_wb_addr),
    .lsu_wb_data     (lsu_wb_data),
    .lsu_misalign    (lsu_misalign),
    .lsu_bus_err     (lsu_bus_err),
    .bus             (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational paths before sampling (well clear of either edge).
  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    mem_access_type = 2'b00;
    mem_access_size = 2'b00;
    mem_sign_ext    = 1'b0;
    mem_addr        = 32'h0;
    mem_wdata       = 32'h0;
    reg_waddr       = 5'd0;
  endtask

  task automatic drive_access(input logic [1:0] typ, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] waddr);
    mem_access_type = typ;
    mem_access_size = sz;
    mem_sign_ext    = sgn;
    mem_addr        = addr;
    mem_wdata       = wdata;
    reg_waddr       = waddr;
  endtask

  // One aligned access. Called right after tick() with the DUT in IDLE. During REQ wait
  // cycles a stray rvalid is offered, which must be ignored.
  task automatic do_access(input string tag, input logic [1:0] typ, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] waddr, input int gnt_dly, input int rv_dly,
                           input logic [31:0] rdata, input logic err,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic exp_wb,
                           input logic [31:0] exp_wb_data, input logic exp_err);
    int stall_cnt;
    stall_cnt = 0;
    drive_access(typ, sz, sgn, addr, wdata, waddr);
    settle();
    check({tag, ".idle_stall"}, {31'b0, lsu_stall}, 32'd1);
    check({tag, ".idle_req"}, {31'b0, bif.bus_req}, 32'd0);
    if (lsu_stall) stall_cnt++;
    tick();
    // Change the decoder inputs: the latched copy must be used from here on.
    drive_access(2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0);
    for (int i = 0; i <= gnt_dly; i++) begin
      bif.bus_gnt    = (i == gnt_dly);
      bif.bus_rvalid = (i < gnt_dly);
      bif.bus_err    = (i < gnt_dly);
      bif.bus_rdata  = 32'h5A5A_5A5A;
      settle();
      check({tag, ".req"}, {31'b0, bif.bus_req}, 32'd1);
      check({tag, ".we"}, {31'b0, bif.bus_we}, {31'b0, (typ == 2'b10)});
      check({tag, ".addr"}, bif.bus_addr, exp_addr);
      check({tag, ".be"}, {28'b0, bif.bus_be}, {28'b0, exp_be});
      check({tag, ".wdata"}, bif.bus_wdata, exp_wdata);
      if (lsu_stall) stall_cnt++;
      tick();
    end
    bif.bus_gnt = 1'b0;
    for (int j = 0; j <= rv_dly; j++) begin
      bif.bus_rvalid = (j == rv_dly);
      bif.bus_err    = (j == rv_dly) ? err : 1'b0;
      bif.bus_rdata  = rdata;
      settle();
      check({tag, ".wait_req"}, {31'b0, bif.bus_req}, 32'd0);
      if (lsu_stall) stall_cnt++;
      tick();
    end
    bif.bus_rvalid = 1'b0;
    bif.bus_err    = 1'b0;
    clear_inputs();
    settle();
    check({tag, ".done_stall"}, {31'b0, lsu_stall}, 32'd0);
    check({tag, ".wb_en"}, {31'b0, lsu_wb_en}, {31'b0, exp_wb});
    check({tag, ".bus_err"}, {31'b0, lsu_bus_err}, {31'b0, exp_err});
    check({tag, ".misalign"}, {31'b0, lsu_misalign}, 32'd0);
    if (exp_wb) begin
      check({tag, ".wb_data"}, lsu_wb_data, exp_wb_data);
      check({tag, ".wb_addr"}, {27'b0, lsu_wb_addr}, {27'b0, waddr});
    end
    check({tag, ".stall_cycles"}, stall_cnt, 3 + gnt_dly + rv_dly);
    tick();
    settle();
    check({tag, ".after_wb_en"}, {31'b0, lsu_wb_en}, 32'd0);
    check({tag, ".after_err"}, {31'b0, lsu_bus_err}, 32'd0);
    check({tag, ".after_req"}, {31'b0, bif.bus_req}, 32'd0);
  endtask

  // Misaligned access: one stall cycle in IDLE, then a DONE with only lsu_misalign.
  task automatic do_misalign(input string tag, input logic [1:0] typ, input logic [1:0] sz,
                             input logic [31:0] addr);
    drive_access(typ, sz, 1'b0, addr, 32'h0, 5'd7);
    settle();
    check({tag, ".idle_stall"}, {31'b0, lsu_stall}, 32'd1);
    check({tag, ".idle_req"}, {31'b0, bif.bus_req}, 32'd0);
    tick();
    clear_inputs();
    settle();
    check({tag, ".misalign"}, {31'b0, lsu_misalign}, 32'd1);
    check({tag, ".done_req"}, {31'b0, bif.bus_req}, 32'd0);
    check({tag, ".done_stall"}, {31'b0, lsu_stall}, 32'd0);
    check({tag, ".done_wb_en"}, {31'b0, lsu_wb_en}, 32'd0);
    tick();
    settle();
    check({tag, ".after_misalign"}, {31'b0, lsu_misalign}, 32'd0);
    check({tag, ".after_req"}, {31'b0, bif.bus_req}, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    clear_inputs();
    bif.bus_gnt    = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata  = 32'h0;
    bif.bus_err    = 1'b0;
    tick();
    tick();
    settle();
    check("rst.stall", {31'b0, lsu_stall}, 32'd0);
    check("rst.req", {31'b0, bif.bus_req}, 32'd0);
    check("rst.wb_en", {31'b0, lsu_wb_en}, 32'd0);
    check("rst.wb_data", lsu_wb_data, 32'h0);
    check("rst.misalign", {31'b0, lsu_misalign}, 32'd0);
    check("rst.bus_err", {31'b0, lsu_bus_err}, 32'd0);
    check("rst.be", {28'b0, bif.bus_be}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    //        tag    typ    sz    sgn  addr          wdata         wa  gd rd rdata         err
    //        exp_addr      be       exp_wdata     wb    wb_data       err
    do_access("lw",   2'b01, 2'b11, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 1'b0,
              32'h100, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_access("lb",   2'b01, 2'b01, 1'b1, 32'h103, 32'h0, 5'd6, 0, 0, 32'h8000_0000, 1'b0,
              32'h100, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    do_access("lbu",  2'b01, 2'b01, 1'b0, 32'h103, 32'h0, 5'd6, 0, 0, 32'h8000_0000, 1'b0,
              32'h100, 4'b1000, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
    do_access("sh",   2'b10, 2'b10, 1'b0, 32'h202, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0, 1'b0,
              32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0);
    do_access("lwerr", 2'b01, 2'b11, 1'b0, 32'h300, 32'h0, 5'd9, 3, 1, 32'h1111_2222, 1'b1,
              32'h300, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1);
    do_access("lh",   2'b01, 2'b10, 1'b1, 32'h102, 32'h0, 5'd3, 1, 2, 32'h8001_7FFF, 1'b0,
              32'h100, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
    do_access("lhu",  2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 0, 0, 32'h8001_F00F, 1'b0,
              32'h100, 4'b0011, 32'h0, 1'b1, 32'h0000_F00F, 1'b0);
    do_access("sb",   2'b10, 2'b01, 1'b0, 32'h101, 32'h0000_0055, 5'd0, 0, 0, 32'h0, 1'b0,
              32'h100, 4'b0010, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
    do_access("sw",   2'b10, 2'b11, 1'b0, 32'h400, 32'hCAFE_F00D, 5'd0, 0, 0, 32'h0, 1'b0,
              32'h400, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    do_access("lbu2", 2'b01, 2'b01, 1'b0, 32'h102, 32'h0, 5'd4, 0, 0, 32'h11A2_3344, 1'b0,
              32'h100, 4'b0100, 32'h0, 1'b1, 32'h0000_00A2, 1'b0);
    do_access("lwx0", 2'b01, 2'b11, 1'b0, 32'h500, 32'h0, 5'd0, 0, 0, 32'h1234_5678, 1'b0,
              32'h500, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0);

    do_misalign("mis_lw", 2'b01, 2'b11, 32'h101);
    do_misalign("mis_sh", 2'b10, 2'b10, 32'h203);

    // Invalid encodings: no stall, no request.
    drive_access(2'b01, 2'b00, 1'b0, 32'h100, 32'h0, 5'd1);
    settle();
    check("inv_size.stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    settle();
    check("inv_size.req", {31'b0, bif.bus_req}, 32'd0);
    drive_access(2'b11, 2'b11, 1'b0, 32'h100, 32'h0, 5'd1);
    settle();
    check("inv_type.stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    settle();
    check("inv_type.req", {31'b0, bif.bus_req}, 32'd0);
    clear_inputs();
    tick();

    // Reset while in WAIT, then a late rvalid that must be ignored.
    drive_access(2'b01, 2'b11, 1'b0, 32'h600, 32'h0, 5'd8);
    tick();
    clear_inputs();
    bif.bus_gnt = 1'b1;
    settle();
    check("rstw.req", {31'b0, bif.bus_req}, 32'd1);
    tick();
    bif.bus_gnt = 1'b0;
    settle();
    check("rstw.wait_stall", {31'b0, lsu_stall}, 32'd1);
    rst_n = 1'b0;
    tick();
    settle();
    check("rstw.req_after", {31'b0, bif.bus_req}, 32'd0);
    check("rstw.stall_after", {31'b0, lsu_stall}, 32'd0);
    rst_n = 1'b1;
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata  = 32'hBAD0_BAD0;
    bif.bus_err    = 1'b1;
    tick();
    bif.bus_rvalid = 1'b0;
    bif.bus_err    = 1'b0;
    settle();
    check("rstw.late_wb_en", {31'b0, lsu_wb_en}, 32'd0);
    check("rstw.late_err", {31'b0, lsu_bus_err}, 32'd0);
    check("rstw.late_stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    settle();
    check("rstw.late2_wb_en", {31'b0, lsu_wb_en}, 32'd0);
    check("rstw.late2_err", {31'b0, lsu_bus_err}, 32'd0);

    // Back to normal operation after the aborted access.
    tick();
    do_access("post", 2'b01, 2'b11, 1'b0, 32'h700, 32'h0, 5'd2, 0, 0, 32'h0BAD_F00D, 1'b0,
              32'h700, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
